// File: rtl/ast_width_narrower_pkg.sv
// Shared types and beat-size helpers for the Avalon-ST width narrower.
// Widths are passed in as byte counts so the functions serve any parameterisation.
package ast_wn_package;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } wn_state_e;

    typedef enum int {
        TEST_MVP,
        TEST_EVERY_SIZE,
        TEST_BACKPRESSURE,
        TEST_RANDOM_BIG
    } test_case;

    // Narrow words needed to carry one wide beat; empty only matters on EOP beats.
    function automatic int words_needed(input int empty, input logic eop,
                                        input int in_b, input int out_b);
        if (!eop) return in_b / out_b;
        return (in_b - empty + out_b - 1) / out_b;
    endfunction

    function automatic int last_empty(input int empty, input int in_b, input int out_b);
        return words_needed(empty, 1'b1, in_b, out_b) * out_b - (in_b - empty);
    endfunction

endpackage

// File: rtl/ast_width_narrower.sv
// Avalon-ST width narrower: splits each wide beat into big-endian narrow words,
// most significant slice first, preserving sop/eop/channel/empty.
//
// state    | meaning
// ST_EMPTY | holding register free; sink ready (once out of reset)
// ST_SEND  | presenting word idx_q of the held beat; last word is idx_q == last_q
module ast_width_narrower
    import ast_wn_package::*;
#(
    parameter int DATA_IN_W   = 256,
    parameter int EMPTY_IN_W  = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1,
    parameter int CHANNEL_W   = 10,
    parameter int DATA_OUT_W  = 64,
    parameter int EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int IN_B  = DATA_IN_W / 8;
    localparam int OUT_B = DATA_OUT_W / 8;
    localparam int RATIO = IN_B / OUT_B;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    wn_state_e              state_q, state_d;
    logic [DATA_IN_W-1:0]   data_q;
    logic                   sop_q;
    logic                   eop_q;
    logic [EMPTY_IN_W-1:0]  empty_q;
    logic [CHANNEL_W-1:0]   chan_q;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic                   rdy_en_q;

    logic                   in_xfer;
    logic                   out_xfer;
    logic                   is_last;
    logic [DATA_OUT_W-1:0]  words [RATIO];
    logic [EMPTY_OUT_W-1:0] eop_empty;

    assign in_xfer  = ast_valid_i & ast_ready_o;
    assign out_xfer = ast_valid_o & ast_ready_i;
    assign is_last  = (idx_q == last_q);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_SEND;
            ST_SEND:  if (out_xfer && is_last && !in_xfer) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Ready is held low through reset and only rises on the first edge after release.
    always_comb begin
        ast_valid_o = (state_q == ST_SEND);
        ast_ready_o = rdy_en_q & ((state_q == ST_EMPTY) |
                                  ((state_q == ST_SEND) & is_last & ast_ready_i));
    end

    always_comb begin
        last_d = IDX_W'(words_needed(int'(ast_empty_i), ast_endofpacket_i, IN_B, OUT_B) - 1);
        idx_d  = idx_q;
        if (in_xfer) begin
            idx_d = '0;
        end else if (out_xfer && !is_last) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            empty_q  <= '0;
            chan_q   <= '0;
            idx_q    <= '0;
            last_q   <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            idx_q    <= idx_d;
            if (in_xfer) begin
                data_q  <= ast_data_i;
                sop_q   <= ast_startofpacket_i;
                eop_q   <= ast_endofpacket_i;
                empty_q <= ast_endofpacket_i ? ast_empty_i : '0;
                chan_q  <= ast_channel_i;
                last_q  <= last_d;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RATIO; i++) begin
            words[i] = data_q[DATA_IN_W-1-i*DATA_OUT_W -: DATA_OUT_W];
        end
    end

    assign eop_empty = EMPTY_OUT_W'(last_empty(int'(empty_q), IN_B, OUT_B));

    always_comb begin
        ast_data_o          = words[idx_q];
        ast_channel_o       = chan_q;
        ast_startofpacket_o = ast_valid_o & sop_q & (idx_q == '0);
        ast_endofpacket_o   = ast_valid_o & eop_q & is_last;
        ast_empty_o         = ast_endofpacket_o ? eop_empty : '0;
    end

endmodule

// File: tb/tb_ast_width_narrower.sv
// Directed bench for ast_width_narrower (256 -> 64): scoreboard of expected narrow
// words, negedge monitor with stall-stability checks, random backpressure phases.
module tb_ast_width_narrower;
    import ast_wn_package::*;

    localparam int DIN  = 256;
    localparam int DOUT = 64;
    localparam int EIN  = 5;
    localparam int EOUT = 3;
    localparam int CW   = 10;

    typedef struct packed {
        logic [DOUT-1:0] data;
        logic            sop;
        logic            eop;
        logic [EOUT-1:0] empty;
        logic [CW-1:0]   ch;
    } word_t;

    logic            clk = 1'b0;
    logic            arstn_i;
    logic [DIN-1:0]  ast_data_i;
    logic            ast_startofpacket_i;
    logic            ast_endofpacket_i;
    logic            ast_valid_i;
    logic [EIN-1:0]  ast_empty_i;
    logic [CW-1:0]   ast_channel_i;
    logic            ast_ready_o;
    logic [DOUT-1:0] ast_data_o;
    logic            ast_startofpacket_o;
    logic            ast_endofpacket_o;
    logic            ast_valid_o;
    logic [EOUT-1:0] ast_empty_o;
    logic [CW-1:0]   ast_channel_o;
    logic            ast_ready_i;

    ast_width_narrower #(
        .DATA_IN_W  (DIN),
        .EMPTY_IN_W (EIN),
        .CHANNEL_W  (CW),
        .DATA_OUT_W (DOUT),
        .EMPTY_OUT_W(EOUT)
    ) dut (
        .clk_i              (clk),
        .arstn_i            (arstn_i),
        .ast_data_i         (ast_data_i),
        .ast_startofpacket_i(ast_startofpacket_i),
        .ast_endofpacket_i  (ast_endofpacket_i),
        .ast_valid_i        (ast_valid_i),
        .ast_empty_i        (ast_empty_i),
        .ast_channel_i      (ast_channel_i),
        .ast_ready_o        (ast_ready_o),
        .ast_data_o         (ast_data_o),
        .ast_startofpacket_o(ast_startofpacket_o),
        .ast_endofpacket_o  (ast_endofpacket_o),
        .ast_valid_o        (ast_valid_o),
        .ast_empty_o        (ast_empty_o),
        .ast_channel_o      (ast_channel_o),
        .ast_ready_i        (ast_ready_i)
    );

    always #5 clk = ~clk;

    word_t    exp_q[$];
    int       xfer_cyc[$];
    int       vectors;
    int       errors;
    int       cyc;
    int       xfers;
    bit       rand_mode;
    bit       force_ready;
    bit       stalled;
    word_t    snap;
    test_case cur_test;

    task automatic chk(input string tag, input logic [DOUT-1:0] obs, input logic [DOUT-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", cur_test.name(), tag, obs, expv);
        end
    endtask

    task automatic chk_w(input string tag, input word_t obs, input word_t expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s/%s: observed data=%h sop=%b eop=%b empty=%0d ch=%0h expected data=%h sop=%b eop=%b empty=%0d ch=%0h",
                   cur_test.name(), tag, obs.data, obs.sop, obs.eop, obs.empty, obs.ch,
                   expv.data, expv.sop, expv.eop, expv.empty, expv.ch);
        end
    endtask

    // Reference model: big-endian split, word count from the number of valid bytes.
    task automatic push_expected(input logic [DIN-1:0] d, input logic sop, input logic eop,
                                 input int empty, input logic [CW-1:0] ch);
        int    vbytes;
        int    n;
        word_t w;
        vbytes = eop ? (32 - empty) : 32;
        n      = (vbytes + 7) / 8;
        for (int k = 0; k < n; k++) begin
            w.data  = d[255-64*k -: 64];
            w.sop   = sop && (k == 0);
            w.eop   = eop && (k == n - 1);
            w.empty = (eop && (k == n - 1)) ? EOUT'(n * 8 - vbytes) : '0;
            w.ch    = ch;
            exp_q.push_back(w);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [DIN-1:0] d, input logic sop, input logic eop,
                             input int empty, input logic [CW-1:0] ch);
        bit done;
        done                = 1'b0;
        ast_valid_i         = 1'b1;
        ast_data_i          = d;
        ast_startofpacket_i = sop;
        ast_endofpacket_i   = eop;
        ast_empty_i         = EIN'(empty);
        ast_channel_i       = ch;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (ast_ready_o) begin
                push_expected(d, sop, eop, empty, ch);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            vectors++;
            errors++;
            $error("FAIL %s/accept-timeout: observed ready_o=0 expected 1 within 300 cycles", cur_test.name());
        end
        ast_valid_i = 1'b0;
    endtask

    task automatic drain(input int bound);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !ast_valid_o) done = 1'b1;
        end
        chk("drain-pending", 64'(exp_q.size()), 64'd0);
    endtask

    logic [DIN-1:0] d_mvp;
    logic [DIN-1:0] d_rnd;
    logic [DIN-1:0] pkt [3];
    int             c0;

    initial begin
        vectors             = 0;
        errors              = 0;
        cyc                 = 0;
        xfers               = 0;
        rand_mode           = 1'b0;
        force_ready         = 1'b1;
        stalled             = 1'b0;
        cur_test            = TEST_MVP;
        arstn_i             = 1'b0;
        ast_valid_i         = 1'b0;
        ast_data_i          = '0;
        ast_startofpacket_i = 1'b0;
        ast_endofpacket_i   = 1'b0;
        ast_empty_i         = '0;
        ast_channel_i       = '0;
        ast_ready_i         = 1'b1;

        fork
            forever begin
                @(posedge clk);
                cyc++;
                #1;
                ast_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : force_ready;
            end
            forever begin
                @(negedge clk);
                if (!arstn_i || !ast_valid_o) begin
                    stalled = 1'b0;
                end else begin
                    word_t cur;
                    cur = '{ast_data_o, ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o};
                    if (stalled) chk_w("stall-hold", cur, snap);
                    if (ast_ready_i) begin
                        xfers++;
                        xfer_cyc.push_back(cyc);
                        if (exp_q.size() == 0) begin
                            vectors++;
                            errors++;
                            $error("FAIL %s/unexpected-word: observed data=%h expected no word", cur_test.name(), cur.data);
                        end else begin
                            chk_w("word", cur, exp_q.pop_front());
                        end
                        stalled = 1'b0;
                    end else begin
                        stalled = 1'b1;
                        snap    = cur;
                    end
                end
            end
        join_none

        // Reset state and ready release timing
        #2;
        chk("rst-ready_o", 64'(ast_ready_o), 64'd0);
        chk("rst-valid_o", 64'(ast_valid_o), 64'd0);
        chk("rst-data_o",  ast_data_o,       64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn_i = 1'b1;
        #1;
        chk("ready-before-edge", 64'(ast_ready_o), 64'd0);
        @(posedge clk);
        #1;
        chk("ready-after-edge", 64'(ast_ready_o), 64'd1);

        // 1: single full beat, counting bytes
        for (int b = 0; b < 32; b++) d_mvp[255-8*b -: 8] = 8'(b);
        c0 = xfers;
        send_beat(d_mvp, 1'b1, 1'b1, 0, 10'h000);
        chk("latency-valid", 64'(ast_valid_o), 64'd1);
        chk("first-word", ast_data_o, 64'h0001020304050607);
        drain(50);
        chk("mvp-count", 64'(xfers - c0), 64'd4);

        // 2 and 3: short EOP beats
        cur_test = TEST_EVERY_SIZE;
        d_rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        c0 = xfers;
        send_beat(d_rnd, 1'b1, 1'b1, 13, 10'h005);
        drain(50);
        chk("empty13-count", 64'(xfers - c0), 64'd3);

        c0 = xfers;
        send_beat(d_mvp, 1'b1, 1'b1, 31, 10'h007);
        chk("one-word-ready_o", 64'(ast_ready_o), 64'd1);
        chk("one-word-empty_o", 64'(ast_empty_o), 64'd7);
        drain(50);
        chk("empty31-count", 64'(xfers - c0), 64'd1);

        for (int e = 0; e < 32; e += 3) begin
            d_rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send_beat(d_rnd, 1'b1, 1'b1, e, 10'(e));
        end
        drain(100);

        // 4: three-beat packet at full rate
        for (int p = 0; p < 3; p++)
            pkt[p] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        c0 = xfers;
        send_beat(pkt[0], 1'b1, 1'b0, 0, 10'h02A);
        send_beat(pkt[1], 1'b0, 1'b0, 0, 10'h02A);
        send_beat(pkt[2], 1'b0, 1'b1, 0, 10'h02A);
        drain(50);
        chk("burst-count", 64'(xfers - c0), 64'd12);
        if (xfers - c0 >= 12) chk("burst-no-gaps", 64'(xfer_cyc[c0+11] - xfer_cyc[c0]), 64'd11);

        // 5: same packet under random backpressure
        cur_test  = TEST_BACKPRESSURE;
        rand_mode = 1'b1;
        c0 = xfers;
        send_beat(pkt[0], 1'b1, 1'b0, 0, 10'h02A);
        send_beat(pkt[1], 1'b0, 1'b0, 0, 10'h02A);
        send_beat(pkt[2], 1'b0, 1'b1, 0, 10'h02A);
        drain(400);
        chk("bp-count", 64'(xfers - c0), 64'd12);

        cur_test = TEST_RANDOM_BIG;
        for (int n = 0; n < 24; n++) begin
            d_rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            send_beat(d_rnd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 31)), 10'($urandom_range(0, 1023)));
        end
        drain(600);
        rand_mode   = 1'b0;
        force_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 6: reset while word 2 of a beat is on the output
        cur_test = TEST_MVP;
        send_beat(d_mvp, 1'b1, 1'b1, 0, 10'h155);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre-reset-word2", ast_data_o, 64'h1011121314151617);
        arstn_i = 1'b0;
        #1;
        chk("mid-rst-valid_o", 64'(ast_valid_o), 64'd0);
        chk("mid-rst-ready_o", 64'(ast_ready_o), 64'd0);
        chk("mid-rst-data_o",  ast_data_o,       64'd0);
        chk("mid-rst-flags",   64'({ast_startofpacket_o, ast_endofpacket_o, ast_empty_o}), 64'd0);
        chk("mid-rst-channel", 64'(ast_channel_o), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arstn_i = 1'b1;
        @(posedge clk);
        #1;
        c0 = xfers;
        send_beat(pkt[1], 1'b1, 1'b1, 0, 10'h033);
        drain(50);
        chk("post-rst-count", 64'(xfers - c0), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
